piso_serializer: RTL and testbench

Parallel-in serial-out stage that sits downstream of the team's 4-bit parallel register. It accepts parallel words through a valid/ready handshake and emits them one bit per cycle with framing flags. A one-word holding buffer lets consecutive words stream with no idle cycles between them. Its serial output feeds the serial link and shift-register stages.

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_serializer_hold_reg.sv | 36 +++
 rtl/piso_serializer.sv | 93 +++++++++
 tb/tb_piso_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
// The default width is shared with the upstream 4-bit parallel register.
package piso_serializer_pkg;

   localparam int unsigned PISO_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

endpackage

// File: rtl/piso_serializer_hold_reg.sv
// Single-entry holding buffer that parks the next word while the current one shifts out.
// Owns the buffered word, its full flag, and the upstream ready signal.
module piso_hold_reg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] hold_o,
   output logic             hold_full_o,
   output logic             d_ready_o
);

   logic [WIDTH-1:0] hold_q;
   logic             full_q;

   // Load and clear never coincide: a load needs ready, which a full buffer withholds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else if (load_i) begin
         hold_q <= d_i;
         full_q <= 1'b1;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end
   end

   assign hold_o      = hold_q;
   assign hold_full_o = full_q;
   assign d_ready_o   = !full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts words over valid/ready and emits one bit per cycle
// with valid/last framing; a one-word holding buffer lets consecutive words stream gap-free.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = PISO_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   output logic             q,
   output logic             q_valid,
   output logic             q_last,
   output logic             busy
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   piso_state_e      state_q;
   logic [WIDTH-1:0] sr_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             ready;
   logic             accept;
   logic             shifting;
   logic             last_bit;
   logic             hold_load;
   logic             hold_clear;
   logic [WIDTH-1:0] sr_shift;

   assign shifting   = (state_q == SHIFT);
   assign accept     = d_valid && ready;
   assign last_bit   = shifting && (cnt_q == CNT_LAST);
   assign hold_load  = accept && shifting && !last_bit;
   assign hold_clear = last_bit && hold_full;
   assign sr_shift   = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

   piso_hold_reg #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk        (clk),
      .rst        (rst),
      .load_i     (hold_load),
      .clear_i    (hold_clear),
      .d_i        (d),
      .hold_o     (hold),
      .hold_full_o(hold_full),
      .d_ready_o  (ready)
   );

   // On the last bit the buffered word wins over a fresh accept; the two cannot both be pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            sr_q    <= d;
            cnt_q   <= '0;
            state_q <= SHIFT;
         end
      end else begin
         if (last_bit) begin
            cnt_q <= '0;
            if (hold_full) begin
               sr_q <= hold;
            end else if (accept) begin
               sr_q <= d;
            end else begin
               sr_q    <= sr_shift;
               state_q <= IDLE;
            end
         end else begin
            sr_q  <= sr_shift;
            cnt_q <= CNT_W'(cnt_q + 1'b1);
         end
      end
   end

   assign d_ready = ready;
   assign q       = shifting && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
   assign q_valid = shifting;
   assign q_last  = last_bit;
   assign busy    = shifting || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: a bit-queue model of the serial stream is compared every cycle,
// plus literal expectations on the captured bit streams of each directed scenario.
module tb_piso_serializer;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] d1  = '0;
   logic         dv1 = 1'b0;
   logic [W-1:0] d2  = '0;
   logic         dv2 = 1'b0;

   logic rdy1, q1, qv1, ql1, bsy1;
   logic rdy2, q2, qv2, ql2, bsy2;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] cap1 = '0;
   int          cnt1 = 0;
   logic [31:0] cap2 = '0;
   int          cnt2 = 0;

   // Model: queue of {bit, is_last} still owed on the serial line; front = current output.
   logic [1:0] mq1[$];
   logic [1:0] mq2[$];

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .d(d1), .d_valid(dv1), .d_ready(rdy1),
      .q(q1), .q_valid(qv1), .q_last(ql1), .busy(bsy1)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .d(d2), .d_valid(dv2), .d_ready(rdy2),
      .q(q2), .q_valid(qv2), .q_last(ql2), .busy(bsy2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clk or posedge rst) begin : model
      bit acc;
      int idx;
      if (rst) begin
         mq1.delete();
         mq2.delete();
      end else begin
         acc = dv1 && (mq1.size() <= W);
         if (mq1.size() > 0) void'(mq1.pop_front());
         if (acc)
            for (int i = 0; i < W; i++) begin
               idx = W - 1 - i;
               mq1.push_back({d1[idx], 1'(i == W - 1)});
            end
         acc = dv2 && (mq2.size() <= W);
         if (mq2.size() > 0) void'(mq2.pop_front());
         if (acc)
            for (int i = 0; i < W; i++)
               mq2.push_back({d2[i], 1'(i == W - 1)});
      end
   end

   // Compare process: every falling edge, both DUTs against the model, and capture valid bits.
   always @(negedge clk) begin : compare
      logic e_v, e_q, e_l;
      e_v = mq1.size() > 0;
      e_q = e_v ? mq1[0][1] : 1'b0;
      e_l = e_v ? mq1[0][0] : 1'b0;
      chk("msb q",       32'(q1),   32'(e_q));
      chk("msb q_valid", 32'(qv1),  32'(e_v));
      chk("msb q_last",  32'(ql1),  32'(e_l));
      chk("msb busy",    32'(bsy1), 32'(e_v));
      chk("msb d_ready", 32'(rdy1), 32'(mq1.size() <= W));
      e_v = mq2.size() > 0;
      e_q = e_v ? mq2[0][1] : 1'b0;
      e_l = e_v ? mq2[0][0] : 1'b0;
      chk("lsb q",       32'(q2),   32'(e_q));
      chk("lsb q_valid", 32'(qv2),  32'(e_v));
      chk("lsb q_last",  32'(ql2),  32'(e_l));
      chk("lsb busy",    32'(bsy2), 32'(e_v));
      chk("lsb d_ready", 32'(rdy2), 32'(mq2.size() <= W));
      if (qv1) begin cap1 = {cap1[30:0], q1}; cnt1++; end
      if (qv2) begin cap2 = {cap2[30:0], q2}; cnt2++; end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clr_cap;
      cap1 = '0; cnt1 = 0; cap2 = '0; cnt2 = 0;
   endtask

   // Present a word on the MSB-first DUT and hold it until an edge with ready high takes it.
   task automatic send1(input logic [W-1:0] w);
      logic r;
      bit   done;
      d1 = w; dv1 = 1'b1; done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk); r = rdy1;
         @(posedge clk); #1;
         if (r) done = 1'b1;
      end
      if (!done) chk("send timeout", 32'd0, 32'd1);
   endtask

   initial begin
      // Reset with a word already offered
      rst = 1'b1; d1 = 4'b1010; dv1 = 1'b1;
      tick(2);
      chk("rst q",       32'(q1),   32'd0);
      chk("rst q_valid", 32'(qv1),  32'd0);
      chk("rst q_last",  32'(ql1),  32'd0);
      chk("rst busy",    32'(bsy1), 32'd0);
      chk("rst d_ready", 32'(rdy1), 32'd1);
      clr_cap();
      rst = 1'b0;
      tick();
      dv1 = 1'b0;
      chk("first bit valid", 32'(qv1), 32'd1);
      chk("first bit", 32'(q1), 32'd1);
      tick(6);
      chk("single word stream", cap1, 32'b1010);
      chk("single word count", 32'(cnt1), 32'd4);
      chk("single idle valid", 32'(qv1), 32'd0);

      // Back-to-back pair through the holding buffer
      clr_cap();
      d1 = 4'b1010; dv1 = 1'b1;
      tick();
      d1 = 4'b0010;
      tick();
      dv1 = 1'b0;
      chk("pair hold ready", 32'(rdy1), 32'd0);
      chk("pair hold busy", 32'(bsy1), 32'd1);
      tick(10);
      chk("pair stream", cap1, 32'b1010_0010);
      chk("pair count", 32'(cnt1), 32'd8);

      // Three words with valid held high
      clr_cap();
      send1(4'b1010);
      send1(4'b0010);
      send1(4'b0001);
      dv1 = 1'b0;
      tick(14);
      chk("triple stream", cap1, 32'b1010_0010_0001);
      chk("triple count", 32'(cnt1), 32'd12);

      // LSB-first instance
      clr_cap();
      d2 = 4'b0001; dv2 = 1'b1;
      tick();
      dv2 = 1'b0;
      tick(6);
      chk("lsb stream", cap2, 32'b1000);
      chk("lsb count", 32'(cnt2), 32'd4);

      // Reset after two bits with a word buffered
      d1 = 4'b1010; dv1 = 1'b1;
      tick();
      d1 = 4'b0010;
      tick();
      dv1 = 1'b0;
      chk("pre-reset hold", 32'(rdy1), 32'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("mid rst q_valid", 32'(qv1),  32'd0);
      chk("mid rst busy",    32'(bsy1), 32'd0);
      chk("mid rst d_ready", 32'(rdy1), 32'd1);
      tick(2);
      rst = 1'b0;
      clr_cap();
      d1 = 4'b0001; dv1 = 1'b1;
      tick();
      dv1 = 1'b0;
      tick(8);
      chk("post rst stream", cap1, 32'b0001);
      chk("post rst count", 32'(cnt1), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
